// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state encoding and arbitration mode constants.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Combinational winner selection: walks the request vector starting at base
// (round-robin) or at index 0 (fixed priority) and reports the first requester.
module rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  input  logic             rr_en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // First requester found in search order wins; grant stays zero if nobody asks.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = rr_en ? IDX_W'((int'(base) + i) % N) : IDX_W'(i);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port cacheline arbiter in front of a single cacheline adaptor.
// Handshake: a port raises req_read/req_write (with address/wdata) and holds it
// until it sees its one-cycle req_resp bit; req_rdata is valid only in that cycle.
// Toward the adaptor, pmem_read/pmem_write stay high and pmem_* stay stable
// until the adaptor pulses pmem_resp for one cycle.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int RR_MODE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [ADDR_W-1:0]           pmem_address,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [LINE_W-1:0]           pmem_wdata,
  input  logic [LINE_W-1:0]           pmem_rdata,
  input  logic                        pmem_resp,
  output logic [1:0]                  dbg_state
);

  localparam int               IDX_W    = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  arb_state_t             state, next_state;
  logic [NUM_PORTS-1:0]   pending;
  logic [NUM_PORTS-1:0]   sel_grant;
  logic [NUM_PORTS-1:0]   grant_q;
  logic [IDX_W-1:0]       sel_index;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       base;
  logic                   sel_write;

  assign pending   = req_read | req_write;
  // Round-robin search begins just past the previous winner, wrapping to 0.
  assign base      = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
  // Write wins when a port raises both read and write.
  assign sel_write = req_write[sel_index];
  assign dbg_state = state;

  rr_select #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_select (
    .req   (pending),
    .base  (base),
    .rr_en (RR_MODE == MODE_RR),
    .grant (sel_grant),
    .index (sel_index)
  );

  // State register; reset aborts any adaptor transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: grant from IDLE, wait for the adaptor in BUSY, one RESP cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|pending) next_state = BUSY;
      BUSY:    if (pmem_resp) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs and winner bookkeeping; pmem_resp only matters in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      req_rdata    <= '0;
      req_resp     <= '0;
      grant_q      <= '0;
      last_grant   <= LAST_IDX;
    end else begin
      req_resp <= '0;
      case (state)
        IDLE: begin
          if (|pending) begin
            grant_q      <= sel_grant;
            last_grant   <= sel_index;
            pmem_address <= req_addr[int'(sel_index)*ADDR_W +: ADDR_W];
            pmem_wdata   <= req_wdata[int'(sel_index)*LINE_W +: LINE_W];
            pmem_write   <= sel_write;
            pmem_read    <= !sel_write;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            req_rdata  <= pmem_rdata;
            req_resp   <= grant_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, meaning the number of requesting cache ports (range 2..8).
REQ-002 The block SHALL have parameter LINE_W, default 256, meaning the cacheline width in bits.
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning the address width in bits.
REQ-004 The block SHALL have parameter RR_MODE, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 0 highest.
REQ-005 clk  in  1  the only clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 req_read  in  NUM_PORTS  per-port line read request, held by the requester until its resp.
REQ-008 req_write  in  NUM_PORTS  per-port line write request, held by the requester until its resp.
REQ-009 req_addr  in  NUM_PORTS*ADDR_W  per-port line address; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  in  NUM_PORTS*LINE_W  per-port write line; port i occupies bits [i*LINE_W +: LINE_W].
REQ-011 req_rdata  out  LINE_W  read line, broadcast to all ports and valid only with req_resp.
REQ-012 req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse.
REQ-013 pmem_address  out  ADDR_W  address to the cacheline adaptor.
REQ-014 pmem_read / pmem_write  out  1 each  requests to the cacheline adaptor; never both high.
REQ-015 pmem_wdata  out  LINE_W  write line to the cacheline adaptor.
REQ-016 pmem_rdata  in  LINE_W  read line from the cacheline adaptor.
REQ-017 pmem_resp  in  1  adaptor completion pulse.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-019 In IDLE, if any port has req_read or req_write high, the FSM SHALL pick a winner, register its index, address, wdata and operation, and move to BUSY on the next edge.
REQ-020 For a request first seen in cycle N, pmem_read or pmem_write SHALL be high from cycle N+1; the outputs SHALL be driven from registers only.
REQ-021 In BUSY, pmem_* SHALL hold stable until pmem_resp; on pmem_resp the FSM SHALL latch pmem_rdata into req_rdata and move to RESP.
REQ-022 In RESP, req_resp[winner] SHALL be high for exactly one cycle, pmem_read and pmem_write SHALL be low, and the next state SHALL be IDLE.
REQ-023 Requesters SHALL drop their request in the cycle after their resp; the minimum gap between two adaptor transactions is therefore one IDLE cycle.
REQ-024 In fixed-priority mode, the lowest-indexed requesting port SHALL win.
REQ-025 In round-robin mode, the search SHALL start at last_grant+1 modulo NUM_PORTS, wrapping from NUM_PORTS-1 to 0, and last_grant SHALL update on every grant.
REQ-026 If a single port raises req_read and req_write together, write SHALL take precedence.
REQ-027 If a granted request drops during BUSY, the adaptor transaction SHALL still complete and the resp SHALL still be pulsed.
REQ-028 pmem_resp SHALL be ignored in IDLE and RESP.
REQ-029 Requests on non-granted ports SHALL wait with no loss; a port SHALL never wait more than NUM_PORTS-1 grants in round-robin mode.

Reset
REQ-030 Reset SHALL force state to IDLE; pmem_read, pmem_write and req_resp to 0; pmem_address, pmem_wdata and req_rdata to 0; and last_grant to NUM_PORTS-1, so port 0 wins first.
REQ-031 Reset asserted during BUSY SHALL abort the transaction without a resp pulse.
REQ-032 After reset deasserts, arbitration SHALL resume from IDLE on the next edge.

Structure
REQ-033 The state enum arb_state_t and the mode constants SHALL reside in the shared rv32i_types package.
REQ-034 Winner selection SHALL be a combinational sub-module rr_select with parameter N, inputs req[N], base index and rr_en, and output a one-hot grant plus a binary index.

Verification
REQ-035 Single read: port 1 reads 0x0000_1000 and the adaptor responds after 4 cycles with 0xA5 pattern -> pmem_read high from cycle N+1, then req_resp=2'b10 for one cycle with req_rdata equal to the pattern.
REQ-036 Simultaneous requests, RR_MODE=1, both ports held for 4 transactions -> grants alternate 0,1,0,1; RR_MODE=0 -> port 0 wins while requesting.
REQ-037 NUM_PORTS=4 with all ports requesting continuously -> grant order 0,1,2,3,0 (wrap) with no starvation.
REQ-038 Port 0 write of 0xDEAD_BEEF line to 0x40 with read also high -> pmem_write high, pmem_read low, and pmem_wdata matches.
REQ-039 Reset pulsed mid-BUSY -> all outputs 0 immediately, no req_resp, and port 0 granted first afterwards.
